// File: rtl/exe_unit_w2_pkg.sv
// Shared types for exe_unit_w2: opcode set, status bit positions, FSM states.
package exe_unit_w2_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned ST_W = 4;

    // Status word bit positions
    localparam int unsigned ST_ZERO = 0;
    localparam int unsigned ST_NEG  = 1;
    localparam int unsigned ST_OVF  = 2;
    localparam int unsigned ST_ERR  = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/exe_mul_seq.sv
// Iterative signed shift-add multiplier: one partial product per cycle,
// the first one taken on the start edge, o_done pulses m cycles after start.
// The sign bit of the multiplier carries negative weight, so the last step subtracts.
module exe_mul_seq
    import exe_unit_w2_pkg::*;
#(
    parameter int unsigned m = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [m-1:0]   i_a,
    input  logic [m-1:0]   i_b,
    output logic           o_done,
    output logic [2*m-1:0] o_prod
);

    localparam int unsigned PW = 2 * m;
    localparam int unsigned CW = $clog2(m);

    logic          busy_q,   busy_d;
    logic          done_q,   done_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [PW-1:0] acc_q,    acc_d;
    logic [PW-1:0] mcand_q,  mcand_d;
    logic [m-1:0]  mplier_q, mplier_d;

    logic [PW-1:0] cur_mcand_c;
    logic [PW-1:0] partial_c;
    logic [m-1:0]  cur_mplier_c;
    logic          last_c;

    // One multiply step per cycle; operands come straight from the inputs on start
    always_comb begin
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        cur_mcand_c  = i_start ? {{m{i_a[m-1]}}, i_a} : mcand_q;
        cur_mplier_c = i_start ? i_b : mplier_q;
        last_c       = i_start ? 1'b0 : (cnt_q == CW'(m - 1));
        partial_c    = '0;
        if (cur_mplier_c[0]) begin
            partial_c = last_c ? (~cur_mcand_c + PW'(1)) : cur_mcand_c;
        end
        if (i_start || busy_q) begin
            acc_d    = (i_start ? '0 : acc_q) + partial_c;
            mcand_d  = cur_mcand_c << 1;
            mplier_d = cur_mplier_c >> 1;
            cnt_d    = i_start ? CW'(1) : cnt_q + CW'(1);
            busy_d   = !last_c;
            done_d   = last_c;
        end
    end

    // Step state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign o_done = done_q;
    assign o_prod = acc_q;

endmodule

// File: rtl/exe_unit_w2.sv
// Registered signed ALU with valid/ready intake and a multi-cycle multiplier.
// Optional build macro: EXE_UNIT_W2_SAT_EN (saturate ADD/SUB/MUL on overflow).
module exe_unit_w2
    import exe_unit_w2_pkg::*;
#(
    parameter int unsigned m = 8,
    parameter int unsigned n = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [n-1:0]    i_oper,
    input  logic [m-1:0]    i_argA,
    input  logic [m-1:0]    i_argB,
    output logic            o_valid,
    output logic [m-1:0]    o_result,
    output logic [ST_W-1:0] o_status
);

    localparam int unsigned PW = 2 * m;

    state_e          state_q,  state_d;
    logic            ready_q,  ready_d;
    logic            valid_q,  valid_d;
    logic [m-1:0]    result_q, result_d;
    logic [ST_W-1:0] status_q, status_d;

    op_e           op_c;
    logic          illegal_c;
    logic          mul_start_c;
    logic          mul_done;
    logic [PW-1:0] mul_prod;

    logic [m:0]           sum_c, diff_c;
    logic signed [m-1:0]  sra_c;
    logic [m-1:0]         alu_res_c;
    logic                 alu_ovf_c, alu_err_c;
    logic [m-1:0]         mul_res_c;
    logic                 mul_ovf_c;

`ifdef EXE_UNIT_W2_SAT_EN
    function automatic logic [m-1:0] sat_val(input logic neg);
        sat_val = neg ? {1'b1, {(m-1){1'b0}}} : {1'b0, {(m-1){1'b1}}};
    endfunction
`endif

    function automatic logic [ST_W-1:0] mk_status(input logic [m-1:0] res,
                                                  input logic ovf, input logic err);
        mk_status          = '0;
        mk_status[ST_ZERO] = (res == '0);
        mk_status[ST_NEG]  = res[m-1];
        mk_status[ST_OVF]  = ovf;
        mk_status[ST_ERR]  = err;
    endfunction

    assign op_c = op_e'(i_oper[OP_W-1:0]);

    // Codes beyond the 3-bit opcode space only exist when n is wider
    generate
        if (n > OP_W) begin : g_wide_op
            assign illegal_c = |i_oper[n-1:OP_W];
        end else begin : g_narrow_op
            assign illegal_c = 1'b0;
        end
    endgenerate

    exe_mul_seq #(.m(m)) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (mul_start_c),
        .i_a     (i_argA),
        .i_b     (i_argB),
        .o_done  (mul_done),
        .o_prod  (mul_prod)
    );

    // Single-cycle datapath; overflow judged on an m+1 bit sign-extended result
    always_comb begin
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        alu_err_c = 1'b0;
        sum_c     = {i_argA[m-1], i_argA} + {i_argB[m-1], i_argB};
        diff_c    = {i_argA[m-1], i_argA} - {i_argB[m-1], i_argB};
        sra_c     = $signed(i_argA) >>> i_argB;
        case (op_c)
            OP_ADD: begin
                alu_res_c = sum_c[m-1:0];
                alu_ovf_c = sum_c[m] ^ sum_c[m-1];
`ifdef EXE_UNIT_W2_SAT_EN
                if (alu_ovf_c) alu_res_c = sat_val(sum_c[m]);
`endif
            end
            OP_SUB: begin
                alu_res_c = diff_c[m-1:0];
                alu_ovf_c = diff_c[m] ^ diff_c[m-1];
`ifdef EXE_UNIT_W2_SAT_EN
                if (alu_ovf_c) alu_res_c = sat_val(diff_c[m]);
`endif
            end
            OP_AND: alu_res_c = i_argA & i_argB;
            OP_OR:  alu_res_c = i_argA | i_argB;
            OP_XOR: alu_res_c = i_argA ^ i_argB;
            OP_SHL: begin
                alu_err_c = (i_argB >= m'(m));
                alu_res_c = alu_err_c ? '0 : (i_argA << i_argB);
            end
            OP_SRA: begin
                alu_err_c = (i_argB >= m'(m));
                alu_res_c = alu_err_c ? {m{i_argA[m-1]}} : sra_c;
            end
            OP_MUL: alu_res_c = '0;
        endcase
        if (illegal_c) begin
            alu_res_c = '0;
            alu_ovf_c = 1'b0;
            alu_err_c = 1'b1;
        end
    end

    // Product fits in m bits only if its top m+1 bits are all equal
    always_comb begin
        mul_ovf_c = !((&mul_prod[PW-1:m-1]) || !(|mul_prod[PW-1:m-1]));
        mul_res_c = mul_prod[m-1:0];
`ifdef EXE_UNIT_W2_SAT_EN
        if (mul_ovf_c) mul_res_c = sat_val(mul_prod[PW-1]);
`endif
    end

    // Next-state and output decode
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        valid_d     = 1'b0;
        result_d    = result_q;
        status_d    = status_q;
        mul_start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    if (op_c == OP_MUL && !illegal_c) begin
                        mul_start_c = 1'b1;
                        state_d     = MUL_BUSY;
                        ready_d     = 1'b0;
                    end else begin
                        valid_d  = 1'b1;
                        result_d = alu_res_c;
                        status_d = mk_status(alu_res_c, alu_ovf_c, alu_err_c);
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    valid_d  = 1'b1;
                    result_d = mul_res_c;
                    status_d = mk_status(mul_res_c, mul_ovf_c, 1'b0);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_status = status_q;

endmodule

// File: tb/tb_exe_unit_w2.sv
// Directed bench for exe_unit_w2 at m=4, n=3.
module tb_exe_unit_w2;
    import exe_unit_w2_pkg::*;

    localparam int unsigned M = 4;
    localparam int unsigned N = 3;

`ifdef EXE_UNIT_W2_SAT_EN
    localparam logic [3:0] T1_RES = 4'b0111, T1_ST = 4'b0100;
    localparam logic [3:0] T2_RES = 4'b1000, T2_ST = 4'b0110;
    localparam logic [3:0] T4_RES = 4'b0111, T4_ST = 4'b0100;
`else
    localparam logic [3:0] T1_RES = 4'b1000, T1_ST = 4'b0110;
    localparam logic [3:0] T2_RES = 4'b0111, T2_ST = 4'b0100;
    localparam logic [3:0] T4_RES = 4'b0000, T4_ST = 4'b0101;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         ready;
    logic [N-1:0] oper;
    logic [M-1:0] arg_a;
    logic [M-1:0] arg_b;
    logic         valid_out;
    logic [M-1:0] result;
    logic [3:0]   status;

    int n_checks = 0;
    int n_fail   = 0;

    exe_unit_w2 #(.m(M), .n(N)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid_in),
        .o_ready  (ready),
        .i_oper   (oper),
        .i_argA   (arg_a),
        .i_argB   (arg_b),
        .o_valid  (valid_out),
        .o_result (result),
        .o_status (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic v);
        oper     = op;
        arg_a    = a;
        arg_b    = b;
        valid_in = v;
    endtask

    initial begin
        rst = 1'b1;
        drive(OP_ADD, 4'h0, 4'h0, 1'b0);
        tick();
        tick();
        check("rst_valid",  8'(valid_out), 8'h0);
        check("rst_ready",  8'(ready),     8'h1);
        check("rst_result", 8'(result),    8'h0);
        check("rst_status", 8'(status),    8'h0);
        rst = 1'b0;
        tick();

        // ADD overflow
        drive(OP_ADD, 4'b0111, 4'b0001, 1'b1);
        tick();
        valid_in = 1'b0;
        check("add_valid",  8'(valid_out), 8'h1);
        check("add_result", 8'(result),    8'(T1_RES));
        check("add_status", 8'(status),    8'(T1_ST));
        tick();
        check("add_valid_drop", 8'(valid_out), 8'h0);
        check("add_hold",       8'(result),    8'(T1_RES));

        // Back-to-back SUB then XOR
        drive(OP_SUB, 4'b1000, 4'b0001, 1'b1);
        tick();
        check("sub_valid",  8'(valid_out), 8'h1);
        check("sub_ready",  8'(ready),     8'h1);
        check("sub_result", 8'(result),    8'(T2_RES));
        check("sub_status", 8'(status),    8'(T2_ST));
        drive(OP_XOR, 4'b1010, 4'b1010, 1'b1);
        tick();
        valid_in = 1'b0;
        check("xor_valid",  8'(valid_out), 8'h1);
        check("xor_ready",  8'(ready),     8'h1);
        check("xor_result", 8'(result),    8'h0);
        check("xor_status", 8'(status),    8'b0001);

        // MUL 3 * -2 with distracting requests during busy
        drive(OP_MUL, 4'b0011, 4'b1110, 1'b1);
        tick();
        drive(OP_ADD, 4'b0001, 4'b0001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("mul_busy_ready",  8'(ready),     8'h0);
            check("mul_busy_valid",  8'(valid_out), 8'h0);
            check("mul_busy_result", 8'(result),    8'h0);
            check("mul_busy_status", 8'(status),    8'b0001);
            tick();
        end
        valid_in = 1'b0;
        check("mul_valid",  8'(valid_out), 8'h1);
        check("mul_ready",  8'(ready),     8'h1);
        check("mul_result", 8'(result),    8'b1010);
        check("mul_status", 8'(status),    8'b0010);
        tick();
        check("mul_valid_drop", 8'(valid_out), 8'h0);
        check("mul_hold",       8'(result),    8'b1010);

        // MUL most-negative squared
        drive(OP_MUL, 4'b1000, 4'b1000, 1'b1);
        tick();
        valid_in = 1'b0;
        repeat (3) tick();
        check("mulneg_early", 8'(valid_out), 8'h0);
        tick();
        check("mulneg_valid",  8'(valid_out), 8'h1);
        check("mulneg_result", 8'(result),    8'(T4_RES));
        check("mulneg_status", 8'(status),    8'(T4_ST));

        // Shifts and logic ops, back to back
        drive(OP_SRA, 4'b1000, 4'b0001, 1'b1);
        tick();
        check("sra1_result", 8'(result), 8'b1100);
        check("sra1_status", 8'(status), 8'b0010);
        drive(OP_SHL, 4'b0011, 4'b0100, 1'b1);
        tick();
        check("shl4_result", 8'(result), 8'b0000);
        check("shl4_status", 8'(status), 8'b1001);
        drive(OP_SRA, 4'b1000, 4'b0101, 1'b1);
        tick();
        check("sra5_result", 8'(result), 8'b1111);
        check("sra5_status", 8'(status), 8'b1010);
        drive(OP_AND, 4'b1100, 4'b1010, 1'b1);
        tick();
        check("and_result", 8'(result), 8'b1000);
        check("and_status", 8'(status), 8'b0010);
        drive(OP_SHL, 4'b0101, 4'b0000, 1'b1);
        tick();
        valid_in = 1'b0;
        check("shl0_result", 8'(result),    8'b0101);
        check("shl0_status", 8'(status),    8'b0000);
        check("shl0_valid",  8'(valid_out), 8'h1);

        // Reset in the middle of a MUL
        drive(OP_MUL, 4'b0011, 4'b0011, 1'b1);
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid",  8'(valid_out), 8'h0);
        check("abort_ready",  8'(ready),     8'h1);
        check("abort_result", 8'(result),    8'h0);
        check("abort_status", 8'(status),    8'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_pulse", 8'(valid_out), 8'h0);
        end
        drive(OP_ADD, 4'b0010, 4'b0011, 1'b1);
        tick();
        valid_in = 1'b0;
        check("post_rst_valid",  8'(valid_out), 8'h1);
        check("post_rst_result", 8'(result),    8'b0101);
        check("post_rst_status", 8'(status),    8'b0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
